// File: rtl/fp32_mul_normround.sv
// fp32_mul_normround: two-stage normalize/round back end for the fp32 multiplier.
// Define FP_SUBNORMAL_EN for gradual underflow; default flushes tiny results to zero.
module fp32_mul_normround (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_mant,
  input  logic [1:0]  in_special,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags
);

  logic               s1_valid_q, s1_valid_d;
  logic               s1_sign_q, s1_sign_d;
  logic [1:0]         s1_special_q, s1_special_d;
  logic signed [10:0] s1_exp_q, s1_exp_d;
  logic [47:0]        s1_mant_q, s1_mant_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_result_q, out_result_d;
  logic [2:0]         out_flags_q, out_flags_d;

  logic               s1_en, s2_en;
  logic [5:0]         lz;
  logic               tiny, lost, g, st, rnd, inx, ovf;
  logic [47:0]        mt;
  logic [24:0]        sum;
  logic signed [10:0] base;
  logic [33:0]        packed_r;
`ifdef FP_SUBNORMAL_EN
  logic signed [10:0] sh;
`endif

  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  // Leading-zero count of the raw product (highest set bit wins).
  always_comb begin
    lz = 6'd48;
    for (int i = 0; i < 48; i++)
      if (in_mant[i]) lz = 6'(47 - i);
  end

  // Stage 1: normalize mantissa, adjust exponent, recode zero products.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_sign_d    = s1_sign_q;
    s1_special_d = s1_special_q;
    s1_exp_d     = s1_exp_q;
    s1_mant_d    = s1_mant_q;
    if (s1_en) s1_valid_d = in_valid;
    if (s1_en && in_valid) begin
      s1_sign_d    = in_sign;
      s1_special_d = (in_special == 2'b00 && in_mant == '0)
                     ? 2'b01 : in_special;
      s1_exp_d     = $signed({in_exp[9], in_exp}) + 11'sd1
                     - $signed({5'b0, lz});
      s1_mant_d    = in_mant << lz;
    end
  end

  // Stage 2 datapath: denormalize if tiny, round to nearest even, pack.
  always_comb begin
    tiny = s1_exp_q < 11'sd1;
    mt   = s1_mant_q;
    lost = 1'b0;
`ifdef FP_SUBNORMAL_EN
    sh = 11'sd1 - s1_exp_q;
    if (tiny) begin
      if (sh >= 11'sd26) begin
        mt   = '0;
        lost = |s1_mant_q;
      end else begin
        mt   = s1_mant_q >> sh[4:0];
        lost = |(s1_mant_q & ~({48{1'b1}} << sh[4:0]));
      end
    end
`endif
    g   = mt[23];
    st  = lost | (|mt[22:0]);
    rnd = g & (st | mt[24]);
    inx = g | st;
    sum = {1'b0, mt[47:24]} + {24'b0, rnd};
    // Hidden bit and rounding carry fold into the exponent by addition.
    base     = tiny ? 11'sd0 : s1_exp_q - 11'sd1;
    packed_r = {base, 23'b0} + {9'b0, sum};
    ovf      = $signed(packed_r[33:23]) >= 11'sd255;
  end

  // Stage 2 control and result selection.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    if (s2_en) out_valid_d = s1_valid_q;
    if (s2_en && s1_valid_q) begin
      unique case (s1_special_q)
        2'b11: begin
          out_result_d = 32'h7FC00000;
          out_flags_d  = 3'b000;
        end
        2'b10: begin
          out_result_d = {s1_sign_q, 8'hFF, 23'b0};
          out_flags_d  = 3'b000;
        end
        2'b01: begin
          out_result_d = {s1_sign_q, 31'b0};
          out_flags_d  = 3'b000;
        end
        default: begin
          if (tiny) begin
`ifdef FP_SUBNORMAL_EN
            out_result_d = {s1_sign_q, packed_r[30:0]};
            out_flags_d  = {1'b0, inx, inx};
`else
            out_result_d = {s1_sign_q, 31'b0};
            out_flags_d  = 3'b011;
`endif
          end else if (ovf) begin
            out_result_d = {s1_sign_q, 8'hFF, 23'b0};
            out_flags_d  = 3'b101;
          end else begin
            out_result_d = {s1_sign_q, packed_r[30:0]};
            out_flags_d  = {2'b00, inx};
          end
        end
      endcase
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_special_q <= 2'b00;
      s1_exp_q     <= '0;
      s1_mant_q    <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_special_q <= s1_special_d;
      s1_exp_q     <= s1_exp_d;
      s1_mant_q    <= s1_mant_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_fp32_mul_normround.sv
// tb_fp32_mul_normround: arithmetic reference model plus directed vectors
// for the fp32 normalize/round back end.
module tb_fp32_mul_normround;

  logic        CLK, nRST;
  logic        in_valid, in_ready, in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_mant;
  logic [1:0]  in_special;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  int total = 0;
  int bad   = 0;
  logic [34:0] expq[$];
  bit rnd_rdy = 0;

  fp32_mul_normround dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp),
    .in_mant(in_mant), .in_special(in_special),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  // Value = mant * 2^(e - 173); result expressed as an integer count of ulps.
  function automatic logic [34:0] ref_model(input logic s,
      input logic [9:0] e10, input logic [47:0] mant,
      input logic [1:0] sp);
    int e, p, be, k;
    longint unsigned m, q, rem, half, n, bits;
    logic inx, tiny, up;
    e = int'($signed(e10));
    m = {16'b0, mant};
    if (sp == 2'b11) return {32'h7FC00000, 3'b000};
    if (sp == 2'b10) return {s, 8'hFF, 23'h0, 3'b000};
    if (sp == 2'b01 || mant == 0) return {s, 31'h0, 3'b000};
    p = 0;
    for (int i = 0; i < 48; i++) if (mant[i]) p = i;
    be = e + p - 46;
    tiny = (be <= 0);
`ifndef FP_SUBNORMAL_EN
    if (tiny) return {s, 31'h0, 3'b011};
`endif
    k = tiny ? 24 - e : p - 23;
    up = 0;
    inx = 0;
    q = 0;
    if (k <= 0) q = m << (-k);
    else if (k >= 60) inx = 1;
    else begin
      q = m >> k;
      rem = m - (q << k);
      half = 64'd1 << (k - 1);
      inx = (rem != 0);
      up = (rem > half) || (rem == half && q[0]);
    end
    n = q + 64'(up);
    if (tiny) bits = n;
    else bits = (64'(be) << 23) + n - (64'd1 << 23);
    if ((bits >> 23) >= 255) return {s, 8'hFF, 23'h0, 3'b101};
    return {s, bits[30:0], 1'b0, tiny & inx, inx};
  endfunction

  task automatic chk(input string nm, input logic [34:0] got,
                     input logic [34:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on drain, check hold.
  initial begin
    logic hold_v;
    logic [34:0] hold_d;
    logic [34:0] w;
    hold_v = 0;
    hold_d = '0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        expq.delete();
        hold_v = 0;
      end else begin
        if (hold_v)
          chk("hold", {out_valid, out_result, out_flags},
              {1'b1, hold_d[34:0]});
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out got=%h want=none", out_result);
          end else begin
            w = expq.pop_front();
            chk("result", {out_result, out_flags}, w);
          end
        end
        hold_v = out_valid && !out_ready;
        hold_d = {out_result, out_flags};
        if (in_valid && in_ready)
          expq.push_back(ref_model(in_sign, in_exp, in_mant, in_special));
      end
    end
  end

  task automatic send(input logic s, input logic [9:0] e,
                      input logic [47:0] m, input logic [1:0] sp);
    bit got;
    got = 0;
    in_sign = s;
    in_exp = e;
    in_mant = m;
    in_special = sp;
    in_valid = 1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge CLK);
      if (in_ready) got = 1;
      @(posedge CLK);
      #1;
      out_ready = 1;
    end
    in_valid = 0;
    if (!got) chk("accept_timeout", 35'd0, 35'd1);
  endtask

  task automatic drain();
    out_ready = 1;
    for (int c = 0; c < 200 && expq.size() != 0; c++) @(negedge CLK);
    chk("drain", 35'(expq.size()), 35'd0);
    @(posedge CLK);
    #1;
  endtask

  localparam logic [47:0] B47 = 48'd1 << 47;
  localparam logic [47:0] B46 = 48'd1 << 46;
  localparam logic [47:0] B24 = 48'd1 << 24;
  localparam logic [47:0] B23 = 48'd1 << 23;
  localparam logic [47:0] B22 = 48'd1 << 22;

  initial begin
    logic [47:0] m;
    logic [9:0] e;
    logic [1:0] sp;
    nRST = 0;
    in_valid = 0;
    in_sign = 0;
    in_exp = '0;
    in_mant = '0;
    in_special = '0;
    out_ready = 1;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_state", {out_valid, out_result, out_flags, in_ready},
        {1'b0, 32'h0, 3'b000, 1'b1});
    nRST = 1;

    chk("m_nominal", ref_model(0, 10'd127, 48'h900000000000, 0),
        {32'h40100000, 3'b000});
    chk("m_tie_even", ref_model(0, 10'd127, B46 | B22, 0),
        {32'h3F800000, 3'b001});
    chk("m_tie_odd", ref_model(0, 10'd127, B46 | B23 | B22, 0),
        {32'h3F800002, 3'b001});
    chk("m_exact_lsb", ref_model(0, 10'd127, B46 | B23, 0),
        {32'h3F800001, 3'b000});
    chk("m_carry", ref_model(0, 10'd127, 48'hFFFFFF800000, 0),
        {32'h40800000, 3'b001});
    chk("m_ovf", ref_model(0, 10'd254, B47, 0), {32'h7F800000, 3'b101});
    chk("m_nan", ref_model(1, 10'd5, B47, 2'b11), {32'h7FC00000, 3'b000});
    chk("m_ninf", ref_model(1, 10'd5, B47, 2'b10), {32'hFF800000, 3'b000});
`ifdef FP_SUBNORMAL_EN
    chk("m_sub", ref_model(0, 10'h3FF, B46, 0), {32'h00200000, 3'b000});
`else
    chk("m_sub", ref_model(0, 10'h3FF, B46, 0), {32'h00000000, 3'b011});
`endif

    send(0, 10'd127, 48'h900000000000, 0);
    send(0, 10'd127, B46 | B22, 0);
    send(0, 10'd127, B46 | B23 | B22, 0);
    send(0, 10'd127, B46 | B23, 0);
    send(0, 10'd127, B46 | B24 | B23, 0);
    send(1, 10'd127, 48'hFFFFFF800000, 0);
    send(0, 10'd254, B47, 0);
    send(1, 10'd511, B47 | 48'd7, 0);
    send(0, 10'h3FF, B46, 0);
    send(0, 10'h3FF, 48'hFFFFFFFFFFFF, 0);
    send(1, 10'h3E0, B47 | 48'd1, 0);
    send(0, 10'h300, B46, 0);
    send(0, 10'd100, 48'd0, 0);
    send(0, 10'd100, 48'd5, 0);
    send(0, 10'd3, B47, 2'b11);
    send(1, 10'd3, B47, 2'b10);
    send(1, 10'd3, B47, 2'b01);
    drain();

    rnd_rdy = 1;
    for (int i = 0; i < 60; i++) begin
      m = {16'($urandom), $urandom};
      case ($urandom_range(0, 3))
        0, 3: m[47] = 1'b1;
        1: begin m[47] = 1'b0; m[46] = 1'b1; end
        default: m = m >> $urandom_range(0, 47);
      endcase
      if ($urandom_range(0, 1) == 1) e = 10'($urandom_range(0, 1023));
      else e = 10'(int'($urandom_range(0, 60)) - 30);
      sp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send(1'($urandom_range(0, 1)), e, m, sp);
    end
    rnd_rdy = 0;
    drain();

    // Backpressure: three products with the output stalled.
    out_ready = 0;
    in_sign = 0;
    in_special = 0;
    in_exp = 10'd127;
    in_mant = B47;
    in_valid = 1;
    @(negedge CLK);
    chk("bp_ready1", 35'(in_ready), 35'd1);
    @(posedge CLK);
    #1;
    in_mant = B47 | B46;
    @(negedge CLK);
    chk("bp_ready2", 35'(in_ready), 35'd1);
    @(posedge CLK);
    #1;
    in_mant = 48'h900000000000;
    @(negedge CLK);
    chk("bp_ready_full", 35'(in_ready), 35'd0);
    repeat (2) @(posedge CLK);
    #1;
    out_ready = 1;
    #1;
    chk("bp_ready_drain", 35'(in_ready), 35'd1);
    @(negedge CLK);
    chk("bp_out1", 35'(out_valid), 35'd1);
    @(posedge CLK);
    #1;
    in_valid = 0;
    @(negedge CLK);
    chk("bp_out2", 35'(out_valid), 35'd1);
    @(negedge CLK);
    chk("bp_out3", 35'(out_valid), 35'd1);
    drain();

    // Reset with both stages full.
    out_ready = 0;
    in_mant = B46;
    in_valid = 1;
    @(posedge CLK);
    #1;
    in_mant = B47;
    @(posedge CLK);
    #1;
    in_valid = 0;
    #2;
    nRST = 0;
    #1;
    chk("rst_async", {out_valid, out_result, out_flags, in_ready},
        {1'b0, 32'h0, 3'b000, 1'b1});
    @(negedge CLK);
    #2;
    nRST = 1;
    out_ready = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk("rst_no_stale", 35'(out_valid), 35'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
